// File: rtl/led_color_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_color_sequencer_if
//   Groups the control and LED-side signals of led_color_sequencer so the
//   sequencer and whatever drives it share a single bundle.
//   Signals:
//     run     master -> slave  1: sequence runs, 0: fade out and freeze
//     led_o   slave -> master  PWM drive to the LEDs (NCH bits)
//     gray_o  slave -> master  current Gray-code target pattern (NCH bits)
//     busy    slave -> master  1 whenever the sequencer FSM is not idle
//   NCH must match the NCH of the attached sequencer.
// ---------------------------------------------------------------------------
interface led_color_sequencer_if #(
  parameter int NCH = 3
);
  logic           run;
  logic [NCH-1:0] led_o;
  logic [NCH-1:0] gray_o;
  logic           busy;

  modport master (
    output run,
    input  led_o,
    input  gray_o,
    input  busy
  );

  modport slave (
    input  run,
    output led_o,
    output gray_o,
    output busy
  );
endinterface

// File: rtl/led_color_sequencer.sv
// ---------------------------------------------------------------------------
// led_color_sequencer
//   N-channel LED colour sequencer. A binary counter is turned into a
//   Gray-code colour pattern. Each channel's brightness level ramps one step
//   per step tick towards MAX_LEVEL (pattern bit set and running) or 0. The
//   level is then turned into a PWM duty. The pattern advances only once every
//   channel has settled on its target, optionally after HOLD_STEPS dwell ticks.
//   Everything runs on clk, and both time bases are clock-enable ticks.
//
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     bus.run    1: sequence runs, 0: all channels fade to 0, pattern frozen
//     bus.led_o  PWM drive per channel (inverted when ACTIVE_LOW != 0)
//     bus.gray_o current Gray-code target pattern
//     bus.busy   1 whenever the FSM is not idle
//
//   Build option:
//     LED_GAMMA_EN  defined   -> duty = floor(level^2 / MAX_LEVEL)
//                   undefined -> duty = level (no multiplier)
// ---------------------------------------------------------------------------
module led_color_sequencer #(
  parameter int NCH        = 3,
  parameter int DEGREE     = 100,
  parameter int MAX_LEVEL  = 50,
  parameter int CLK_DIV    = 240,
  parameter int STEP_DIV   = 1200000,
  parameter int HOLD_STEPS = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_color_sequencer_if.slave  bus
);

  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int DW = $clog2(DEGREE + 1);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [DW-1:0] PWM_LAST  = DW'(DEGREE - 1);
  localparam logic [LW-1:0] LVL_MAX   = LW'(MAX_LEVEL);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic          POL_INV   = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           clk_cnt_q, clk_cnt_d;
  logic [SW-1:0]           step_cnt_q, step_cnt_d;
  logic [DW-1:0]           pwm_cnt_q, pwm_cnt_d;
  logic [NCH-1:0][LW-1:0]  level_q, level_d;
  logic [NCH-1:0][DW-1:0]  duty_q, duty_d;
  logic [NCH-1:0][DW-1:0]  duty_new;
  logic [NCH-1:0][LW-1:0]  target;
  logic [NCH-1:0]          bin_q, bin_d;
  logic [NCH-1:0]          gray_q, gray_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [NCH-1:0]          led_q, led_d;
  logic                    busy_q, busy_d;
  logic                    pwm_tick, step_tick, pwm_wrap;
  logic                    at_tgt, all_zero;

  // Level-to-duty mapping. The gamma variant squares the level and rescales
  // so that 0 and MAX_LEVEL map to themselves.
`ifdef LED_GAMMA_EN
  localparam int PRW = 2 * LW;
  localparam logic [PRW-1:0] MAX_LEVEL_W = PRW'(MAX_LEVEL);
  logic [NCH-1:0][PRW-1:0] level_sq;

  always_comb begin
    level_sq = '0;
    duty_new = '0;
    for (int i = 0; i < NCH; i++) begin
      level_sq[i] = PRW'(level_q[i]) * PRW'(level_q[i]);
      duty_new[i] = DW'(level_sq[i] / MAX_LEVEL_W);
    end
  end
`else
  always_comb begin
    duty_new = '0;
    for (int i = 0; i < NCH; i++) begin
      duty_new[i] = DW'(level_q[i]);
    end
  end
`endif

  // Prescalers, PWM counter, duty latch and pin drive. The duty is reloaded
  // only as the PWM counter wraps to 0, so a period never changes width
  // halfway through.
  always_comb begin
    pwm_tick   = (clk_cnt_q == CLK_LAST);
    step_tick  = (step_cnt_q == STEP_LAST);
    pwm_wrap   = pwm_tick && (pwm_cnt_q == PWM_LAST);
    clk_cnt_d  = pwm_tick  ? '0 : clk_cnt_q + CW'(1);
    step_cnt_d = step_tick ? '0 : step_cnt_q + SW'(1);
    pwm_cnt_d  = pwm_cnt_q;
    if (pwm_tick) begin
      pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + DW'(1);
    end
    duty_d = pwm_wrap ? duty_new : duty_q;
    led_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      led_d[i] = (pwm_cnt_q < duty_q[i]) ^ POL_INV;
    end
  end

  // Sequencer FSM and level ramp. Targets and the at-target test both use
  // the levels as they stand before this tick moves them.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    target     = '0;
    at_tgt     = 1'b1;
    all_zero   = 1'b1;

    for (int i = 0; i < NCH; i++) begin
      target[i] = (bus.run && gray_q[i]) ? LVL_MAX : '0;
      if (level_q[i] != target[i]) at_tgt = 1'b0;
      if (level_q[i] != '0)        all_zero = 1'b0;
    end

    if (step_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.run) state_d = ST_RAMP;
        end
        ST_RAMP: begin
          if (!bus.run && all_zero) begin
            state_d = ST_IDLE;
          end else if (bus.run && at_tgt) begin
            if (HOLD_STEPS == 0) begin
              bin_d = bin_q + NCH'(1);
            end else begin
              state_d    = ST_HOLD;
              hold_cnt_d = '0;
            end
          end
        end
        ST_HOLD: begin
          if (!bus.run) begin
            state_d = ST_RAMP;
          end else if (hold_cnt_q == HOLD_LAST) begin
            bin_d   = bin_q + NCH'(1);
            state_d = ST_RAMP;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Upward moves also stop at MAX_LEVEL so a level can never overshoot.
      for (int i = 0; i < NCH; i++) begin
        if ((level_q[i] < target[i]) && (level_q[i] < LVL_MAX)) begin
          level_d[i] = level_q[i] + LW'(1);
        end else if (level_q[i] > target[i]) begin
          level_d[i] = level_q[i] - LW'(1);
        end
      end
    end

    gray_d = bin_d ^ (bin_d >> 1);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      step_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      level_q    <= '0;
      duty_q     <= '0;
      bin_q      <= '0;
      gray_q     <= '0;
      hold_cnt_q <= '0;
      led_q      <= {NCH{POL_INV}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      step_cnt_q <= step_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      duty_q     <= duty_d;
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.led_o  = led_q;
  assign bus.gray_o = gray_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_led_color_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_color_sequencer
//   Drives led_color_sequencer with long random run/stop segments and
//   compares led_o, gray_o and busy every clock against a behavioural model
//   built from edge-count arithmetic and the sequencing rules. Also checks
//   the reset state and an asynchronous reset taken while a LED is lit.
//   Honours LED_GAMMA_EN in the model's level-to-duty mapping.
// ---------------------------------------------------------------------------
module tb_led_color_sequencer;

  localparam int NCH        = 3;
  localparam int DEGREE     = 10;
  localparam int MAX_LEVEL  = 5;
  localparam int CLK_DIV    = 2;
  localparam int STEP_DIV   = 20;
  localparam int HOLD_STEPS = 2;
  localparam int ACTIVE_LOW = 0;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_RAMP  = 1;
  localparam int MODE_HOLD  = 2;
  localparam int PAT_MASK   = (1 << NCH) - 1;

  logic clk;
  logic rst_n;

  led_color_sequencer_if #(.NCH(NCH)) bus_if ();

  led_color_sequencer #(
    .NCH        (NCH),
    .DEGREE     (DEGREE),
    .MAX_LEVEL  (MAX_LEVEL),
    .CLK_DIV    (CLK_DIV),
    .STEP_DIV   (STEP_DIV),
    .HOLD_STEPS (HOLD_STEPS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model state
  int edge_n;
  int mdl_pwm;
  int mdl_bin;
  int mdl_mode;
  int mdl_hold;
  int mdl_level [NCH];
  int mdl_duty  [NCH];
  bit [NCH-1:0] mdl_led;

  function automatic int duty_of(input int lvl);
`ifdef LED_GAMMA_EN
    return (lvl * lvl) / MAX_LEVEL;
`else
    return lvl;
`endif
  endfunction

  function automatic logic [NCH-1:0] pins_of(input bit [NCH-1:0] on);
    return (ACTIVE_LOW != 0) ? ~on : on;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d, t=%0t)",
               tag, observed, expected, edge_n, $time);
    end
  endtask

  task automatic model_reset();
    edge_n   = 0;
    mdl_pwm  = 0;
    mdl_bin  = 0;
    mdl_mode = MODE_IDLE;
    mdl_hold = 0;
    mdl_led  = '0;
    for (int i = 0; i < NCH; i++) begin
      mdl_level[i] = 0;
      mdl_duty[i]  = 0;
    end
  endtask

  // One clock edge of the reference. Tick instants come from the edge count;
  // the pin value reflects the PWM position and duty before this edge.
  task automatic model_edge(input bit run_v);
    int  tgt [NCH];
    int  gray;
    bit  at_t;
    bit  zero;
    edge_n++;
    for (int i = 0; i < NCH; i++) mdl_led[i] = (mdl_pwm < mdl_duty[i]);
    if (edge_n % (CLK_DIV * DEGREE) == 0) begin
      for (int i = 0; i < NCH; i++) mdl_duty[i] = duty_of(mdl_level[i]);
    end
    mdl_pwm = (edge_n / CLK_DIV) % DEGREE;
    if (edge_n % STEP_DIV == 0) begin
      gray = mdl_bin ^ (mdl_bin >> 1);
      at_t = 1'b1;
      zero = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        tgt[i] = (run_v && ((gray >> i) & 1)) ? MAX_LEVEL : 0;
        if (mdl_level[i] != tgt[i]) at_t = 1'b0;
        if (mdl_level[i] != 0)      zero = 1'b0;
      end
      case (mdl_mode)
        MODE_IDLE: if (run_v) mdl_mode = MODE_RAMP;
        MODE_RAMP: begin
          if (!run_v && zero) mdl_mode = MODE_IDLE;
          else if (run_v && at_t) begin
            if (HOLD_STEPS == 0) mdl_bin = (mdl_bin + 1) & PAT_MASK;
            else begin
              mdl_mode = MODE_HOLD;
              mdl_hold = 0;
            end
          end
        end
        default: begin
          if (!run_v) mdl_mode = MODE_RAMP;
          else if (mdl_hold == HOLD_STEPS - 1) begin
            mdl_bin  = (mdl_bin + 1) & PAT_MASK;
            mdl_mode = MODE_RAMP;
          end else mdl_hold++;
        end
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (mdl_level[i] < tgt[i])      mdl_level[i]++;
        else if (mdl_level[i] > tgt[i]) mdl_level[i]--;
      end
    end
  endtask

  // Holds run at run_v for the given number of clocks, checking every edge.
  // Entered and left between a negedge and the following posedge.
  task automatic applyStimulus(input bit run_v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus_if.run = run_v;
      @(posedge clk);
      model_edge(run_v);
      #1;
      checkOutput("led_o",  32'(bus_if.led_o),  32'(pins_of(mdl_led)));
      checkOutput("gray_o", 32'(bus_if.gray_o), 32'((mdl_bin ^ (mdl_bin >> 1)) & PAT_MASK));
      checkOutput("busy",   32'(bus_if.busy),   32'(mdl_mode != MODE_IDLE));
      @(negedge clk);
    end
  endtask

  initial begin
    bit found;
    bus_if.run = 1'b0;
    rst_n      = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_led",  32'(bus_if.led_o),  32'(pins_of('0)));
    checkOutput("rst_gray", 32'(bus_if.gray_o), 32'd0);
    checkOutput("rst_busy", 32'(bus_if.busy),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle with run low, then a long run to walk the full Gray sequence
    applyStimulus(1'b0, 1000);
    applyStimulus(1'b1, 3000);

    // Random run/stop segments, from brief glitches to full cycles
    for (int s = 0; s < 30; s++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(20, 1500));
    end

    // Asynchronous reset while channel 0 is lit
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      applyStimulus(1'b1, 1);
      if (mdl_led[0]) found = 1'b1;
    end
    checkOutput("led0_lit_wait", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_led",  32'(bus_if.led_o),  32'(pins_of('0)));
    checkOutput("async_rst_gray", 32'(bus_if.gray_o), 32'd0);
    checkOutput("async_rst_busy", 32'(bus_if.busy),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    applyStimulus(1'b1, 2000);
    applyStimulus(1'b0, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
